// File: rtl/svc_rv_mem_arb.sv
// Shares one single-ported, fixed-latency memory between the svc_rv fetch (I) and data (D) ports.
// Data has priority, fetch gets a bounded starvation guard, and read responses are routed back in grant order.
module svc_rv_mem_arb #(
   parameter int XLEN         = 32,
   parameter int READ_LATENCY = 1,
   parameter int STARVE_MAX   = 4
) (
   input  logic              clock,
   input  logic              reset,

   input  logic              i_req_valid,
   output logic              i_req_ready,
   input  logic [XLEN-1:0]   i_req_addr,
   output logic              i_rsp_valid,
   output logic [XLEN-1:0]   i_rsp_rdata,

   input  logic              d_req_valid,
   output logic              d_req_ready,
   input  logic              d_req_we,
   input  logic [XLEN-1:0]   d_req_addr,
   input  logic [XLEN-1:0]   d_req_wdata,
   input  logic [XLEN/8-1:0] d_req_wstrb,
   output logic              d_rsp_valid,
   output logic [XLEN-1:0]   d_rsp_rdata,

   output logic              mem_ren,
   output logic              mem_we,
   output logic [XLEN-1:0]   mem_addr,
   output logic [XLEN-1:0]   mem_wdata,
   output logic [XLEN/8-1:0] mem_wstrb,
   input  logic [XLEN-1:0]   mem_rdata
);

   typedef enum logic {
      OWNER_I = 1'b0,
      OWNER_D = 1'b1
   } owner_e;

   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   logic [3:0] starve_cnt;
   logic       grant_i;
   logic       grant_d;
   logic       rd_grant;
   owner_e     rd_owner;

   logic       trk_valid [READ_LATENCY];
   owner_e     trk_owner [READ_LATENCY];

   // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      grant_d = 1'b0;
      grant_i = 1'b0;
      if (!reset) begin
         grant_d = d_req_valid && (!i_req_valid || (starve_cnt < STARVE_LIM));
         grant_i = i_req_valid && !grant_d;
      end
   end

   assign i_req_ready = grant_i;
   assign d_req_ready = grant_d;

   always_comb begin
      mem_ren   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_wstrb = '0;
      if (grant_i) begin
         mem_ren  = 1'b1;
         mem_addr = i_req_addr;
      end else if (grant_d) begin
         mem_addr = d_req_addr;
         if (d_req_we) begin
            mem_we    = 1'b1;
            mem_wdata = d_req_wdata;
            mem_wstrb = d_req_wstrb;
         end else begin
            mem_ren = 1'b1;
         end
      end
   end

   assign rd_grant = grant_i || (grant_d && !d_req_we);
   assign rd_owner = grant_d ? OWNER_D : OWNER_I;

   // Count consecutive cycles fetch waited; any cycle without a pending fetch breaks the run.
   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         starve_cnt <= '0;
      end else if (!i_req_valid || grant_i) begin
         starve_cnt <= '0;
      end else if (starve_cnt < STARVE_LIM) begin
         starve_cnt <= starve_cnt + 4'd1;
      end
   end

   // Tracker entries are control state, so they are reset; the async clear drops rsp_valid at once.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < READ_LATENCY; k++) begin
            trk_valid[k] <= 1'b0;
            trk_owner[k] <= OWNER_I;
         end
      end else begin
         for (int k = READ_LATENCY - 1; k > 0; k--) begin
            trk_valid[k] <= trk_valid[k-1];
            trk_owner[k] <= trk_owner[k-1];
         end
         trk_valid[0] <= rd_grant;
         trk_owner[0] <= rd_owner;
      end
   end

   assign i_rsp_valid = trk_valid[READ_LATENCY-1] && (trk_owner[READ_LATENCY-1] == OWNER_I);
   assign d_rsp_valid = trk_valid[READ_LATENCY-1] && (trk_owner[READ_LATENCY-1] == OWNER_D);
   assign i_rsp_rdata = i_rsp_valid ? mem_rdata : '0;
   assign d_rsp_rdata = d_rsp_valid ? mem_rdata : '0;

endmodule
